layer2_ifm_pad_writer: RTL

//  Downstream of the layer-1 PE cluster. Collects each 16-channel OFM beat (128 b) and writes it into the layer-2 IFM BRAM.
//  The BRAM holds a zero-padded image, so layer 2 (3x3 depthwise) reads halo pixels without special cases.

---
 rtl/layer2_ifm_pad_writer_pkg.sv | 18 +
 rtl/layer2_ifm_pad_writer_if.sv | 16 +
 rtl/layer2_ifm_pad_writer_walker.sv | 85 ++++++++
 rtl/layer2_ifm_pad_writer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/layer2_ifm_pad_writer_pkg.sv
// Shared types and constants for the layer-2 IFM padded-image writer.
package mbconv_pkg;

    localparam int CH_PER_TILE = 16;
    localparam int OFM_BEAT_W  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pad_wr_state_t;

    // Number of 16-channel tiles; any remainder channels are ignored.
    function automatic logic [3:0] ofm_tiles(input logic [7:0] ofm_c, input int ch_per_t);
        return 4'(ofm_c / 8'(ch_per_t));
    endfunction

endpackage

// File: rtl/layer2_ifm_pad_writer_if.sv
// OFM beat input and BRAM write port of the layer-2 IFM writer.
interface layer2_ifm_pad_writer_if
    import mbconv_pkg::*;
#(
    parameter int DATA_W = OFM_BEAT_W,
    parameter int ADDR_W = 32
);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output valid_in, output data_in, input wr_en, input wr_addr, input wr_data);
    modport slave  (input valid_in, input data_in, output wr_en, output wr_addr, output wr_data);
endinterface

// File: rtl/layer2_ifm_pad_writer_walker.sv
// Walks the zero border of every tile of the padded image, one word per grant.
module pad_border_walker
    import mbconv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              en,
    input  logic              grant,
    input  logic [8:0]        pw,
    input  logic [3:0]        tiles,
    input  logic [ADDR_W-1:0] base,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              finished
);
    logic              active_q, active_d;
    logic [8:0]        row_q, row_d, col_q, col_d;
    logic [3:0]        tile_q, tile_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic              last_col_s, last_row_s, jump_s;

    // Next position along the border; tiles are contiguous so the offset only ever grows.
    always_comb begin
        active_d   = active_q;
        row_d      = row_q;
        col_d      = col_q;
        tile_d     = tile_q;
        off_d      = off_q;
        last_col_s = (col_q == pw - 9'd1);
        last_row_s = (row_q == pw - 9'd1);
        jump_s     = (row_q != 9'd0) && !last_row_s && (col_q == 9'd0);
        if (start) begin
            active_d = en;
            row_d    = 9'd0;
            col_d    = 9'd0;
            tile_d   = 4'd0;
            off_d    = '0;
        end else if (grant && active_q) begin
            off_d = off_q + (jump_s ? ADDR_W'(pw - 9'd1) : ADDR_W'(1'b1));
            if (jump_s) begin
                col_d = pw - 9'd1;
            end else if (last_col_s) begin
                col_d = 9'd0;
                if (last_row_s) begin
                    row_d = 9'd0;
                    if (tile_q == tiles - 4'd1) begin
                        active_d = 1'b0;
                    end else begin
                        tile_d = tile_q + 4'd1;
                    end
                end else begin
                    row_d = row_q + 9'd1;
                end
            end else begin
                col_d = col_q + 9'd1;
            end
        end else begin
            active_d = active_q;
        end
    end

    // Walker state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            row_q    <= 9'd0;
            col_q    <= 9'd0;
            tile_q   <= 4'd0;
            off_q    <= '0;
        end else begin
            active_q <= active_d;
            row_q    <= row_d;
            col_q    <= col_d;
            tile_q   <= tile_d;
            off_q    <= off_d;
        end
    end

    assign req      = active_q;
    assign finished = !active_q;
    assign addr     = base + off_q;
endmodule

// File: rtl/layer2_ifm_pad_writer.sv
// Writes layer-1 OFM beats into the zero-padded layer-2 IFM BRAM and fills the border itself.
module layer2_ifm_pad_writer
    import mbconv_pkg::*;
#(
    parameter int DATA_W   = OFM_BEAT_W,
    parameter int ADDR_W   = 32,
    parameter int CH_PER_T = CH_PER_TILE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [7:0]                     OFM_W,
    input  logic [7:0]                     OFM_C,
    input  logic                           pad_en,
    input  logic [ADDR_W-1:0]              base_addr,
    layer2_ifm_pad_writer_if.slave         bus,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    pad_wr_state_t     state_q, state_d;
    logic [7:0]        w_q, w_d, row_q, row_d, col_q, col_d;
    logic              pad_q, pad_d;
    logic [ADDR_W-1:0] base_q, base_d, ip_q, ip_d, wr_addr_q, wr_addr_d;
    logic [8:0]        pw_q, pw_d;
    logic [3:0]        tiles_q, tiles_d, tiles_s;
    logic [15:0]       total_q, total_d, pix_cnt_q, pix_cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              walker_start_s, walker_en_s, grant_s, walker_req_s, walker_fin_s;
    logic [ADDR_W-1:0] walker_addr_s;

    assign tiles_s     = ofm_tiles(OFM_C, CH_PER_T);
    assign walker_en_s = pad_en && (tiles_s != 4'd0);

    pad_border_walker #(.ADDR_W(ADDR_W)) u_walker (
        .clk      (clk),
        .reset    (reset),
        .start    (walker_start_s),
        .en       (walker_en_s),
        .grant    (grant_s),
        .pw       (pw_q),
        .tiles    (tiles_q),
        .base     (base_q),
        .req      (walker_req_s),
        .addr     (walker_addr_s),
        .finished (walker_fin_s)
    );

    // FSM, interior pointer and write-port arbitration (beats always win).
    always_comb begin
        state_d = state_q;   w_d = w_q;       pad_d = pad_q;     base_d = base_q;
        pw_d = pw_q;         tiles_d = tiles_q; total_d = total_q; pix_cnt_d = pix_cnt_q;
        row_d = row_q;       col_d = col_q;   ip_d = ip_q;
        wr_en_d = 1'b0;      wr_addr_d = wr_addr_q; wr_data_d = wr_data_q;
        done_d = 1'b0;       err_d = err_q;
        walker_start_s = 1'b0;
        grant_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    w_d       = OFM_W;
                    pad_d     = pad_en;
                    base_d    = base_addr;
                    pw_d      = {1'b0, OFM_W} + (pad_en ? 9'd2 : 9'd0);
                    tiles_d   = tiles_s;
                    total_d   = 16'({8'd0, OFM_W} * {8'd0, OFM_W}) * {12'd0, tiles_s};
                    pix_cnt_d = 16'd0;
                    row_d     = 8'd0;
                    col_d     = 8'd0;
                    ip_d      = base_addr + (pad_en ? ADDR_W'(OFM_W) + ADDR_W'(2'd3) : '0);
                    err_d     = 1'b0;
                    walker_start_s = 1'b1;
                end else begin
                    walker_start_s = 1'b0;
                end
                if (bus.valid_in) begin
                    err_d = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
            end
            RUN: begin
                if (bus.valid_in) begin
                    if (pix_cnt_q != total_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ip_q;
                        wr_data_d = bus.data_in;
                        pix_cnt_d = pix_cnt_q + 16'd1;
                        if (col_q == w_q - 8'd1) begin
                            col_d = 8'd0;
                            if (row_q == w_q - 8'd1) begin
                                row_d = 8'd0;
                                ip_d  = ip_q + (pad_q ? ADDR_W'({w_q, 1'b0}) + ADDR_W'(3'd7)
                                                      : ADDR_W'(1'b1));
                            end else begin
                                row_d = row_q + 8'd1;
                                ip_d  = ip_q + (pad_q ? ADDR_W'(2'd3) : ADDR_W'(1'b1));
                            end
                        end else begin
                            col_d = col_q + 8'd1;
                            ip_d  = ip_q + ADDR_W'(1'b1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (walker_req_s) begin
                    grant_s   = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = walker_addr_s;
                    wr_data_d = '0;
                end else begin
                    grant_s = 1'b0;
                end
                if ((pix_cnt_q == total_q) && walker_fin_s) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.valid_in) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;  w_q <= 8'd0;     pad_q <= 1'b0;     base_q <= '0;
            pw_q <= 9'd0;     tiles_q <= 4'd0; total_q <= 16'd0;  pix_cnt_q <= 16'd0;
            row_q <= 8'd0;    col_q <= 8'd0;   ip_q <= '0;
            wr_en_q <= 1'b0;  wr_addr_q <= '0; wr_data_q <= '0;
            busy_q <= 1'b0;   done_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;  w_q <= w_d;         pad_q <= pad_d;      base_q <= base_d;
            pw_q <= pw_d;        tiles_q <= tiles_d; total_q <= total_d;  pix_cnt_q <= pix_cnt_d;
            row_q <= row_d;      col_q <= col_d;     ip_q <= ip_d;
            wr_en_q <= wr_en_d;  wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d;
            busy_q <= busy_d;    done_q <= done_d;   err_q <= err_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
